// File: rtl/flash_prog_ctrl_if.sv
// ---------------------------------------------------------------------------
// flash_prog_ctrl_if
// Bundles the CPU register-window signals and the parallel flash bus used by
// flash_prog_ctrl.
//   CPU side : cctl_n, r_w, cart_a, cart_d_in  -> controller
//              reg_rd_en, reg_rd_data           <- controller
//   Flash    : rom_a, rom_d_out, rom_d_oe, ce_n, oe_n, we_n <- controller
//              rom_d_in                                      -> controller
//   Status   : own, busy                                     <- controller
// Modports: slave = the controller, master = host/top level and flash.
// ---------------------------------------------------------------------------
interface flash_prog_ctrl_if;
    logic        cctl_n;
    logic        r_w;
    logic [7:0]  cart_a;
    logic [7:0]  cart_d_in;
    logic        reg_rd_en;
    logic [7:0]  reg_rd_data;
    logic        own;
    logic        busy;
    logic [18:0] rom_a;
    logic [7:0]  rom_d_out;
    logic        rom_d_oe;
    logic [7:0]  rom_d_in;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;

    modport master (
        output cctl_n, r_w, cart_a, cart_d_in, rom_d_in,
        input  reg_rd_en, reg_rd_data, own, busy,
        input  rom_a, rom_d_out, rom_d_oe, ce_n, oe_n, we_n
    );

    modport slave (
        input  cctl_n, r_w, cart_a, cart_d_in, rom_d_in,
        output reg_rd_en, reg_rd_data, own, busy,
        output rom_a, rom_d_out, rom_d_oe, ce_n, oe_n, we_n
    );
endinterface

// File: rtl/flash_prog_ctrl.sv
// ---------------------------------------------------------------------------
// flash_prog_ctrl
// In-system programming sequencer for an SST39SF040-class 512k x 8 flash.
// The host fills ADDR/DATA through an 8-byte window in $D5xx CCTL space and
// writes a command; the block then owns the ROM bus, issues the JEDEC unlock
// and command writes, polls the DQ6 toggle bit until it settles and reports
// busy/error/done in STATUS.
// Ports:
//   phi2  - clock, all state changes on the rising edge
//   reset - synchronous, active high
//   bus   - flash_prog_ctrl_if.slave (CPU window, flash bus, own/busy)
// Optional feature: define FLASH_PROG_AUTOINC_EN to advance ADDR by one
// (wrapping 7FFFF->00000) after each successful byte program.
// ---------------------------------------------------------------------------
module flash_prog_ctrl #(
    parameter logic [4:0]  BASE      = 5'b11000,
    parameter logic [19:0] TIMEOUT   = 20'd400000,
    parameter int          WP_CYCLES = 1
) (
    input  logic              phi2,
    input  logic              reset,
    flash_prog_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, P_RD1, P_RD2, RECOVER} state_t;
    typedef enum logic [1:0] {OP_PROG, OP_SECTOR, OP_CHIP, OP_ABORT} op_t;

    localparam logic [2:0] WP = 3'(WP_CYCLES);

    state_t      state;
    op_t         op;
    op_t         cmd_op;
    logic        cmd_valid;
    logic [18:0] addr;
    logic [7:0]  data;
    logic        error, done, own, busy;
    logic [2:0]  step, pulse_cnt;
    logic [1:0]  rec_phase;
    logic [19:0] to_cnt;
    logic        have_prev, prev_dq6;
    logic [18:0] rom_a;
    logic [7:0]  rom_d_out;
    logic        rom_d_oe, ce_n, oe_n, we_n;
    logic        hit, wr_hit, cur_last;
    logic [2:0]  offset;
    logic [26:0] first_entry, next_entry;

    // Address/data of one step of the JEDEC sequence for a given operation.
    function automatic logic [26:0] seq_entry(input op_t o, input logic [2:0] idx,
                                              input logic [18:0] a, input logic [7:0] d);
        logic [26:0] e;
        e = {19'h05555, 8'hAA};
        if (o == OP_ABORT) begin
            e = {19'h00000, 8'hF0};
        end else begin
            case (idx)
                3'd0:    e = {19'h05555, 8'hAA};
                3'd1:    e = {19'h02AAA, 8'h55};
                3'd2:    e = {19'h05555, (o == OP_PROG) ? 8'hA0 : 8'h80};
                3'd3:    e = (o == OP_PROG) ? {a, d} : {19'h05555, 8'hAA};
                3'd4:    e = {19'h02AAA, 8'h55};
                default: e = (o == OP_SECTOR) ? {a[18:12], 12'h000, 8'h30} : {19'h05555, 8'h10};
            endcase
        end
        return e;
    endfunction

    assign offset      = bus.cart_a[2:0];
    assign hit         = ~bus.cctl_n & (bus.cart_a[7:3] == BASE);
    assign wr_hit      = hit & ~bus.r_w;
    assign first_entry = seq_entry(cmd_op, 3'd0, addr, data);
    assign next_entry  = seq_entry(op, step + 3'd1, addr, data);
    assign cur_last    = (op == OP_ABORT) ? (step == 3'd0) :
                         (op == OP_PROG)  ? (step == 3'd3) : (step == 3'd5);

    // Command byte decode; anything outside 01..04 is dropped.
    always_comb begin
        cmd_valid = 1'b1;
        cmd_op    = OP_PROG;
        case (bus.cart_d_in)
            8'h01:   cmd_op = OP_PROG;
            8'h02:   cmd_op = OP_SECTOR;
            8'h03:   cmd_op = OP_CHIP;
            8'h04:   cmd_op = OP_ABORT;
            default: cmd_valid = 1'b0;
        endcase
    end

    // Register window read mux; the top level gates it onto cart_d.
    always_comb begin
        bus.reg_rd_data = 8'h00;
        case (offset)
            3'd0:    bus.reg_rd_data = addr[7:0];
            3'd1:    bus.reg_rd_data = addr[15:8];
            3'd2:    bus.reg_rd_data = {5'b00000, addr[18:16]};
            3'd3:    bus.reg_rd_data = data;
            3'd5:    bus.reg_rd_data = {busy, error, done, 5'b00000};
            default: bus.reg_rd_data = 8'h00;
        endcase
    end

    assign bus.reg_rd_en = hit & bus.r_w;
    assign bus.own       = own;
    assign bus.busy      = busy;
    assign bus.rom_a     = rom_a;
    assign bus.rom_d_out = rom_d_out;
    assign bus.rom_d_oe  = rom_d_oe;
    assign bus.ce_n      = ce_n;
    assign bus.oe_n      = oe_n;
    assign bus.we_n      = we_n;

    // Register writes plus the sequencer. Strobes are registered and are
    // loaded with the values of the state being entered, so every bus phase
    // is glitch-free. The poll read is sampled on the P_RD1->P_RD2 edge while
    // oe_n is still low. Later assignments (FSM) override the STATUS clear
    // when both happen on the same edge.
    always_ff @(posedge phi2) begin
        if (reset) begin
            state     <= IDLE;
            op        <= OP_PROG;
            addr      <= 19'h00000;
            data      <= 8'h00;
            error     <= 1'b0;
            done      <= 1'b0;
            own       <= 1'b0;
            busy      <= 1'b0;
            step      <= 3'd0;
            pulse_cnt <= 3'd0;
            rec_phase <= 2'd0;
            to_cnt    <= 20'd0;
            have_prev <= 1'b0;
            prev_dq6  <= 1'b0;
            rom_a     <= 19'h00000;
            rom_d_out <= 8'h00;
            rom_d_oe  <= 1'b0;
            ce_n      <= 1'b1;
            oe_n      <= 1'b1;
            we_n      <= 1'b1;
        end else begin
            if (wr_hit) begin
                case (offset)
                    3'd0:    if (!busy) addr[7:0]   <= bus.cart_d_in;
                    3'd1:    if (!busy) addr[15:8]  <= bus.cart_d_in;
                    3'd2:    if (!busy) addr[18:16] <= bus.cart_d_in[2:0];
                    3'd3:    if (!busy) data        <= bus.cart_d_in;
                    3'd5: begin
                        error <= 1'b0;
                        done  <= 1'b0;
                    end
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (wr_hit && offset == 3'd4 && cmd_valid) begin
                        op        <= cmd_op;
                        step      <= 3'd0;
                        rom_a     <= first_entry[26:8];
                        rom_d_out <= first_entry[7:0];
                        rom_d_oe  <= 1'b1;
                        ce_n      <= 1'b0;
                        oe_n      <= 1'b1;
                        we_n      <= 1'b1;
                        own       <= 1'b1;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        done      <= 1'b0;
                        state     <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    we_n      <= 1'b0;
                    pulse_cnt <= 3'd1;
                    state     <= W_PULSE;
                end
                W_PULSE: begin
                    if (pulse_cnt == WP) begin
                        we_n  <= 1'b1;
                        ce_n  <= 1'b1;
                        state <= W_HOLD;
                    end else begin
                        pulse_cnt <= pulse_cnt + 3'd1;
                    end
                end
                W_HOLD: begin
                    if (!cur_last) begin
                        step      <= step + 3'd1;
                        rom_a     <= next_entry[26:8];
                        rom_d_out <= next_entry[7:0];
                        ce_n      <= 1'b0;
                        state     <= W_SETUP;
                    end else if (op == OP_ABORT) begin
                        done     <= 1'b1;
                        own      <= 1'b0;
                        busy     <= 1'b0;
                        rom_d_oe <= 1'b0;
                        rom_a    <= 19'h00000;
                        state    <= IDLE;
                    end else begin
                        rom_d_oe  <= 1'b0;
                        rom_a     <= addr;
                        ce_n      <= 1'b0;
                        oe_n      <= 1'b0;
                        to_cnt    <= 20'd0;
                        have_prev <= 1'b0;
                        state     <= P_RD1;
                    end
                end
                P_RD1: begin
                    to_cnt <= to_cnt + 20'd1;
                    if (have_prev && prev_dq6 == bus.rom_d_in[6]) begin
                        if (op == OP_PROG && bus.rom_d_in != data) error <= 1'b1;
`ifdef FLASH_PROG_AUTOINC_EN
                        else if (op == OP_PROG) addr <= addr + 19'd1;
`endif
                        done     <= 1'b1;
                        own      <= 1'b0;
                        busy     <= 1'b0;
                        ce_n     <= 1'b1;
                        oe_n     <= 1'b1;
                        rom_a    <= 19'h00000;
                        state    <= IDLE;
                    end else if (to_cnt + 20'd1 == TIMEOUT) begin
                        error     <= 1'b1;
                        rom_a     <= 19'h00000;
                        rom_d_out <= 8'hF0;
                        rom_d_oe  <= 1'b1;
                        ce_n      <= 1'b0;
                        oe_n      <= 1'b1;
                        rec_phase <= 2'd0;
                        state     <= RECOVER;
                    end else begin
                        prev_dq6  <= bus.rom_d_in[6];
                        have_prev <= 1'b1;
                        ce_n      <= 1'b1;
                        oe_n      <= 1'b1;
                        state     <= P_RD2;
                    end
                end
                P_RD2: begin
                    to_cnt <= to_cnt + 20'd1;
                    if (to_cnt + 20'd1 == TIMEOUT) begin
                        error     <= 1'b1;
                        rom_a     <= 19'h00000;
                        rom_d_out <= 8'hF0;
                        rom_d_oe  <= 1'b1;
                        ce_n      <= 1'b0;
                        rec_phase <= 2'd0;
                        state     <= RECOVER;
                    end else begin
                        ce_n  <= 1'b0;
                        oe_n  <= 1'b0;
                        state <= P_RD1;
                    end
                end
                RECOVER: begin
                    // Single F0 reset write: setup, WP_CYCLES pulse, hold.
                    case (rec_phase)
                        2'd0: begin
                            we_n      <= 1'b0;
                            pulse_cnt <= 3'd1;
                            rec_phase <= 2'd1;
                        end
                        2'd1: begin
                            if (pulse_cnt == WP) begin
                                we_n      <= 1'b1;
                                ce_n      <= 1'b1;
                                rec_phase <= 2'd2;
                            end else begin
                                pulse_cnt <= pulse_cnt + 3'd1;
                            end
                        end
                        default: begin
                            done     <= 1'b1;
                            own      <= 1'b0;
                            busy     <= 1'b0;
                            rom_d_oe <= 1'b0;
                            rom_a    <= 19'h00000;
                            state    <= IDLE;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_prog_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flash_prog_ctrl
// Self-checking bench for flash_prog_ctrl. Stimulus tasks push the expected
// flash write cycles and register read values into queues; a monitor
// compares them as the DUT completes bus writes or presents read data.
// A small flash model answers poll reads with a toggling DQ6 and then a
// settled value.
// ---------------------------------------------------------------------------
module tb_flash_prog_ctrl;
    localparam logic [4:0]  BASE    = 5'b11000;
    localparam logic [19:0] TIMEOUT = 20'd100;
    localparam int          WP      = 2;

    logic phi2  = 1'b0;
    logic reset = 1'b1;

    flash_prog_ctrl_if bus();

    flash_prog_ctrl #(.BASE(BASE), .TIMEOUT(TIMEOUT), .WP_CYCLES(WP)) dut (
        .phi2  (phi2),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 phi2 = ~phi2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [18:0] a; logic [7:0] d; } wr_t;
    typedef struct { string name; logic [7:0] v; } rd_t;
    wr_t wq[$];
    rd_t rq[$];

    // Reference state: what the host believes ADDR/DATA hold.
    logic [18:0] m_addr = 19'h0;
    logic [7:0]  m_data = 8'h0;
    logic        m_busy = 1'b0;
    int          poll_cycles = 0;

    // Flash model: toggles_left < 0 means DQ6 toggles forever.
    int          toggles_left = 0;
    logic        tog = 1'b0;
    logic [7:0]  final_val = 8'hFF;

    assign bus.rom_d_in = (toggles_left != 0) ? {1'b0, tog, 6'b000000} : final_val;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Bus monitor and scoreboard checker.
    initial begin : monitor
        logic        prev_we;
        logic        prev_rd;
        int          low_cnt;
        logic [18:0] cap_a;
        logic [7:0]  cap_d;
        wr_t         ew;
        rd_t         er;
        prev_we = 1'b1;
        prev_rd = 1'b0;
        low_cnt = 0;
        cap_a   = '0;
        cap_d   = '0;
        forever begin
            @(negedge phi2);
            if (reset) begin
                prev_we = 1'b1;
                prev_rd = 1'b0;
                low_cnt = 0;
            end else begin
                n_checks++;
                if ((!bus.we_n && !bus.oe_n) || (!bus.oe_n && bus.rom_d_oe)) begin
                    n_fail++;
                    $display("[TB] FAIL strobe_conflict: we_n=%b oe_n=%b rom_d_oe=%b, required no overlap",
                             bus.we_n, bus.oe_n, bus.rom_d_oe);
                end
                if (bus.own && !bus.rom_d_oe) poll_cycles++;
                if (prev_rd && bus.oe_n && toggles_left != 0) begin
                    if (toggles_left > 0) toggles_left--;
                    tog = ~tog;
                end
                prev_rd = !bus.ce_n && !bus.oe_n;
                if (!bus.we_n) begin
                    low_cnt++;
                    cap_a = bus.rom_a;
                    cap_d = bus.rom_d_out;
                    checkOutput("pulse_ce_n_and_oe", {30'd0, bus.ce_n, bus.rom_d_oe}, 32'd1);
                end else if (!prev_we) begin
                    if (wq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_write: got %05h/%02h, expected none", cap_a, cap_d);
                    end else begin
                        ew = wq.pop_front();
                        checkOutput("write_addr", 32'(cap_a), 32'(ew.a));
                        checkOutput("write_data", 32'(cap_d), 32'(ew.d));
                        checkOutput("we_low_cycles", low_cnt, WP);
                    end
                    low_cnt = 0;
                end
                prev_we = bus.we_n;
                if (bus.reg_rd_en) begin
                    if (rq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_read: got %02h, expected none", bus.reg_rd_data);
                    end else begin
                        er = rq.pop_front();
                        checkOutput(er.name, 32'(bus.reg_rd_data), 32'(er.v));
                    end
                end
            end
        end
    end

    // One CPU write cycle into the register window.
    task automatic applyStimulus(input logic [2:0] off, input logic [7:0] val);
        @(posedge phi2); #2;
        bus.cctl_n    = 1'b0;
        bus.r_w       = 1'b0;
        bus.cart_a    = {BASE, off};
        bus.cart_d_in = val;
        @(posedge phi2); #2;
        bus.cctl_n = 1'b1;
        bus.r_w    = 1'b1;
    endtask

    task automatic hostWrite(input logic [2:0] off, input logic [7:0] val);
        if (!m_busy) begin
            case (off)
                3'd0: m_addr[7:0]   = val;
                3'd1: m_addr[15:8]  = val;
                3'd2: m_addr[18:16] = val[2:0];
                3'd3: m_data        = val;
                default: ;
            endcase
        end
        applyStimulus(off, val);
    endtask

    task automatic readReg(input logic [2:0] off, input logic [7:0] expv, input string name);
        rq.push_back('{name, expv});
        @(posedge phi2); #2;
        bus.cctl_n = 1'b0;
        bus.r_w    = 1'b1;
        bus.cart_a = {BASE, off};
        @(posedge phi2); #2;
        bus.cctl_n = 1'b1;
    endtask

    task automatic setAddr(input logic [18:0] a);
        hostWrite(3'd0, a[7:0]);
        hostWrite(3'd1, a[15:8]);
        hostWrite(3'd2, {5'b00000, a[18:16]});
    endtask

    task automatic setFlash(input int toggles, input logic [7:0] fv);
        toggles_left = toggles;
        final_val    = fv;
    endtask

    // op: 1 program, 2 sector erase, 3 chip erase, 4 abort.
    task automatic startOp(input int op);
        logic [18:0] sa;
        if (op == 4) begin
            wq.push_back('{19'h00000, 8'hF0});
        end else begin
            wq.push_back('{19'h05555, 8'hAA});
            wq.push_back('{19'h02AAA, 8'h55});
            if (op == 1) begin
                wq.push_back('{19'h05555, 8'hA0});
                wq.push_back('{m_addr, m_data});
            end else begin
                wq.push_back('{19'h05555, 8'h80});
                wq.push_back('{19'h05555, 8'hAA});
                wq.push_back('{19'h02AAA, 8'h55});
                sa = {m_addr[18:12], 12'h000};
                if (op == 2) wq.push_back('{sa, 8'h30});
                else         wq.push_back('{19'h05555, 8'h10});
            end
        end
        poll_cycles = 0;
        applyStimulus(3'd4, 8'(op));
        m_busy = 1'b1;
    endtask

    task automatic finishOp(input int op, input logic timeout_exp);
        int   n;
        logic err;
        n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge phi2);
            n++;
        end
        if (bus.busy) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL busy_clear: busy still %b after %0d cycles, required 0", bus.busy, n);
        end
        m_busy = 1'b0;
        err = timeout_exp || (op == 1 && final_val != m_data);
`ifdef FLASH_PROG_AUTOINC_EN
        if (op == 1 && !err) m_addr = m_addr + 19'd1;
`endif
        checkOutput("writes_drained", wq.size(), 0);
        checkOutput("own_released", {31'd0, bus.own}, 32'd0);
        readReg(3'd5, {1'b0, err, 1'b1, 5'b00000}, "status");
        readReg(3'd0, m_addr[7:0], "addr_lo");
        readReg(3'd1, m_addr[15:8], "addr_mid");
        readReg(3'd2, {5'b00000, m_addr[18:16]}, "addr_hi");
    endtask

    task automatic waitPoll();
        int n;
        n = 0;
        while (!(bus.own && !bus.rom_d_oe) && n < 200) begin
            @(negedge phi2);
            n++;
        end
        checkOutput("reached_poll", {31'd0, bus.own && !bus.rom_d_oe}, 32'd1);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        n_fail++;
        summary();
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0]  d;
        logic [7:0]  fv;
        logic [7:0]  flip;
        logic [18:0] a;
        int          op;
        int          n;

        bus.cctl_n    = 1'b1;
        bus.r_w       = 1'b1;
        bus.cart_a    = 8'h00;
        bus.cart_d_in = 8'h00;
        repeat (3) @(posedge phi2);
        #2 reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_ce_n", {31'd0, bus.ce_n}, 32'd1);
        checkOutput("rst_we_n", {31'd0, bus.we_n}, 32'd1);
        checkOutput("rst_oe_n", {31'd0, bus.oe_n}, 32'd1);
        checkOutput("rst_own", {31'd0, bus.own}, 32'd0);
        checkOutput("rst_rom_a", 32'(bus.rom_a), 32'd0);
        readReg(3'd5, 8'h00, "rst_status");
        readReg(3'd0, 8'h00, "rst_addr_lo");
        readReg(3'd3, 8'h00, "rst_data");

        $display("[TB] register map");
        hostWrite(3'd2, 8'hFF);
        readReg(3'd2, {5'b00000, m_addr[18:16]}, "addr_hi_mask");
        hostWrite(3'd6, 8'h55);
        readReg(3'd6, 8'h00, "reg6_zero");
        readReg(3'd7, 8'h00, "reg7_zero");
        readReg(3'd4, 8'h00, "cmd_reads_zero");
        applyStimulus(3'd4, 8'h07);
        checkOutput("unknown_cmd_idle", {31'd0, bus.busy}, 32'd0);

        $display("[TB] program pass/fail");
        setAddr(19'h12345);
        hostWrite(3'd3, 8'h5A);
        setFlash(3, 8'h5A);
        startOp(1);
        finishOp(1, 1'b0);
        setAddr(19'h12345);
        setFlash(3, 8'h5B);
        startOp(1);
        finishOp(1, 1'b0);

        $display("[TB] sector erase");
        setAddr(19'h2C123);
        setFlash(12, 8'hFF);
        startOp(2);
        waitPoll();
        readReg(3'd5, 8'h80, "status_busy_poll");
        finishOp(2, 1'b0);

        $display("[TB] timeout");
        setFlash(-1, 8'hFF);
        startOp(1);
        wq.push_back('{19'h00000, 8'hF0});
        finishOp(1, 1'b1);
        checkOutput("timeout_poll_cycles", {31'd0, poll_cycles >= int'(TIMEOUT) && poll_cycles <= int'(TIMEOUT) + 2}, 32'd1);

        $display("[TB] writes while busy");
        setAddr(19'h00111);
        hostWrite(3'd3, 8'h33);
        setFlash(20, 8'h33);
        startOp(1);
        hostWrite(3'd0, 8'hAA);
        hostWrite(3'd2, 8'h05);
        hostWrite(3'd3, 8'h00);
        applyStimulus(3'd4, 8'h02);
        readReg(3'd0, m_addr[7:0], "addr_lo_busy");
        readReg(3'd3, m_data, "data_busy");
        finishOp(1, 1'b0);

        $display("[TB] reset during write pulse");
        setFlash(50, 8'hFF);
        startOp(1);
        n = 0;
        while (bus.we_n && n < 100) begin
            @(negedge phi2);
            n++;
        end
        checkOutput("saw_we_pulse", {31'd0, bus.we_n}, 32'd0);
        #1 reset = 1'b1;
        @(posedge phi2); #1;
        checkOutput("midrst_we_n", {31'd0, bus.we_n}, 32'd1);
        checkOutput("midrst_ce_n", {31'd0, bus.ce_n}, 32'd1);
        checkOutput("midrst_own", {31'd0, bus.own}, 32'd0);
        checkOutput("midrst_rom_d_oe", {31'd0, bus.rom_d_oe}, 32'd0);
        @(negedge phi2); #1;
        reset = 1'b0;
        wq.delete();
        m_busy = 1'b0;
        m_addr = 19'h0;
        m_data = 8'h0;
        setFlash(0, 8'hFF);
        readReg(3'd5, 8'h00, "midrst_status");
        readReg(3'd1, 8'h00, "midrst_addr_mid");
        startOp(4);
        finishOp(4, 1'b0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(1, 3);
            a  = 19'($urandom);
            d  = 8'($urandom_range(0, 255));
            flip = 8'h01 << $urandom_range(0, 7);
            fv = (op != 1) ? 8'hFF : (($urandom_range(0, 1) == 1) ? d : (d ^ flip));
            setAddr(a);
            hostWrite(3'd3, d);
            setFlash($urandom_range(1, 6), fv);
            startOp(op);
            finishOp(op, 1'b0);
        end

        $display("[TB] address wrap");
        setAddr(19'h7FFFF);
        hostWrite(3'd3, 8'hC3);
        setFlash(2, 8'hC3);
        startOp(1);
        finishOp(1, 1'b0);

        repeat (4) @(posedge phi2);
        checkOutput("read_queue_drained", rq.size(), 0);
        checkOutput("write_queue_drained", wq.size(), 0);
        summary();
        $finish;
    end
endmodule
